// File: rtl/router_pkg.sv
// Shared constants for the router FIFO: geometry, header marker position
// and the packet-length field inside a header byte.
package router_pkg;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_WIDTH = 9;
  localparam int HDR_BIT    = 8;
  localparam int LEN_MSB    = 7;
  localparam int LEN_LSB    = 2;
  localparam int PTR_W      = 5;
  localparam int CNT_W      = 7;
endpackage

// File: rtl/router_fifo.sv
// Router output FIFO: stores bytes tagged with a header marker and tracks the
// remaining byte count of the packet being read so the output idles at 00.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       soft_reset,
  input  logic       write_enb,
  input  logic       read_enb,
  input  logic       lfd_state,
  input  logic [7:0] data_in,
  output logic       full,
  output logic       empty,
  output logic [7:0] data_out
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [CNT_W-1:0] pkt_cnt;
  logic             lfd_d;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] rd_entry;

  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty    = (wr_ptr == rd_ptr);
  assign wr_en    = write_enb && !full && !soft_reset;
  assign rd_en    = read_enb && !empty;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  // Storage is deliberately left out of reset; cleared pointers hide it.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= WIDTH'({lfd_d, data_in});
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      lfd_d    <= 1'b0;
      data_out <= 8'h00;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      lfd_d    <= 1'b0;
      data_out <= 8'h00;
    end else begin
      lfd_d <= lfd_state;
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) begin
        rd_ptr   <= rd_ptr + (AW+1)'(1);
        data_out <= rd_entry[7:0];
        // Header length counts payload bytes; +1 covers the trailing parity byte.
        if (rd_entry[HDR_BIT])
          pkt_cnt <= CNT_W'(rd_entry[LEN_MSB:LEN_LSB]) + CNT_W'(1);
        else if (pkt_cnt != '0)
          pkt_cnt <= pkt_cnt - CNT_W'(1);
      end else if (pkt_cnt == '0) begin
        data_out <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_router_fifo;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [8:0] m_q[$];
  int         m_cnt;
  logic [7:0] m_dout;
  logic       m_lfd;
  int         m_rd_total;
  int         m_wr_total;

  router_fifo dut (
    .clock     (clock),
    .resetn    (resetn),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .read_enb  (read_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .full      (full),
    .empty     (empty),
    .data_out  (data_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_cnt      = 0;
    m_dout     = 8'h00;
    m_lfd      = 1'b0;
    m_rd_total = 0;
    m_wr_total = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".full"},   32'(full),         32'(m_q.size() == 16));
    check({tag, ".empty"},  32'(empty),        32'(m_q.size() == 0));
    check({tag, ".dout"},   32'(data_out),     32'(m_dout));
    check({tag, ".cnt"},    32'(dut.pkt_cnt),  32'(m_cnt));
    check({tag, ".rdptr"},  32'(dut.rd_ptr),   32'(m_rd_total % 32));
    check({tag, ".wrptr"},  32'(dut.wr_ptr),   32'(m_wr_total % 32));
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input string tag, input logic we, input logic re, input logic lfd,
                      input logic sr, input logic [7:0] din);
    logic [8:0] e;
    bit         do_rd;
    bit         do_wr;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    soft_reset = sr;
    data_in    = din;
    if (sr) begin
      model_clear();
    end else begin
      do_rd = re && (m_q.size() != 0);
      do_wr = we && (m_q.size() != 16);
      if (do_rd) begin
        e = m_q.pop_front();
        m_dout = e[7:0];
        m_rd_total++;
        if (e[8]) m_cnt = int'(e[7:2]) + 1;
        else if (m_cnt != 0) m_cnt--;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (do_wr) begin
        m_q.push_back({m_lfd, din});
        m_wr_total++;
      end
      m_lfd = lfd;
    end
    @(posedge clock);
    #1;
    compare_all(tag);
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    compare_all("rst");
    resetn = 1'b1;

    // asynchronous reset after a preload
    for (int i = 0; i < 3; i++) step("pre", 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h30 + i));
    check("pre.empty", 32'(empty), 32'd0);
    #3;
    resetn = 1'b0;
    #1;
    model_clear();
    check("async.empty", 32'(empty), 32'd1);
    check("async.full",  32'(full),  32'd0);
    check("async.dout",  32'(data_out), 32'h00);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // packet: header 16 -> length 5 payload + parity
    step("lfd", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    begin
      logic [7:0] pkt [7];
      pkt = '{8'h16, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hE1};
      for (int i = 0; i < 7; i++) step("pkt.wr", 1'b1, 1'b0, 1'b0, 1'b0, pkt[i]);
      for (int i = 0; i < 7; i++) begin
        step("pkt.rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("pkt.byte", 32'(data_out), 32'(pkt[i]));
        if (i == 0) check("pkt.hdrcnt", 32'(dut.pkt_cnt), 32'd6);
      end
      check("pkt.endcnt", 32'(dut.pkt_cnt), 32'd0);
      step("pkt.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check("pkt.idle00", 32'(data_out), 32'h00);
    end

    // full: 17 writes, last dropped
    for (int i = 0; i < 17; i++) begin
      step("full.wr", 1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      if (i == 14) check("full.15", 32'(full), 32'd0);
      if (i == 15) check("full.16", 32'(full), 32'd1);
    end
    for (int i = 0; i < 16; i++) begin
      step("full.rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("full.byte", 32'(data_out), 32'(i));
    end
    check("full.empty", 32'(empty), 32'd1);

    // simultaneous read/write at occupancy 8, then at full
    for (int i = 0; i < 8; i++) step("sim.pre", 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) step("sim.rw", 1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));
    check("sim.occ8", 32'(m_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) step("sim.fill", 1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
    check("sim.full", 32'(full), 32'd1);
    step("sim.rwfull", 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
    check("sim.occ15", 32'(full), 32'd0);

    // soft reset mid-packet, then a fresh header 0A
    step("sr", 1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
    check("sr.empty", 32'(empty), 32'd1);
    check("sr.dout",  32'(data_out), 32'h00);
    step("sr.lfd", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step("sr.hdr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h0A);
    step("sr.rd",  1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("sr.byte", 32'(data_out), 32'h0A);
    check("sr.cnt",  32'(dut.pkt_cnt), 32'd3);

    // read while empty holds data_out and rd_ptr
    step("em.drain", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step("em.rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("em.dout", 32'(data_out), 32'(m_dout));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step("rnd",
           1'($urandom_range(0, 99) < 55),
           1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 8),
           1'($urandom_range(0, 999) < 5),
           8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clock  input  1  rising-edge system clock.
REQ-003 Port: resetn  input  1  asynchronous active-low reset.
REQ-004 Port: soft_reset  input  1  synchronous active-high flush from the sync block on read timeout.
REQ-005 Port: write_enb  input  1  write request, one byte per cycle.
REQ-006 Port: read_enb  input  1  read request from the output port.
REQ-007 Port: lfd_state  input  1  FSM "load first data" flag; header is on data_in one cycle later.
REQ-008 Port: data_in  input  8  byte from the register stage (its dout).
REQ-009 Port: full  output  1  16 entries occupied.
REQ-010 Port: empty  output  1  0 entries occupied.
REQ-011 Port: data_out  output  8  registered read data.
REQ-012 Parameter: DEPTH, default 16, number of entries (power of 2).
REQ-013 Parameter: WIDTH, default 9, entry width: bit 8 is the header marker and bits 7:0 are the data.

Function
REQ-014 Storage SHALL be a DEPTH x WIDTH array with 5-bit write and read pointers; the MSB of each pointer is the wrap bit.
REQ-015 Flags: full = (wr_ptr[3:0]==rd_ptr[3:0]) and wrap bits differ; empty = pointers equal; both are combinational from the pointers.
REQ-016 lfd_d SHALL be lfd_state registered by one clock, aligned with the one-cycle register-stage latency.
REQ-017 A write SHALL occur when write_enb=1 and full=0, storing {lfd_d, data_in} at wr_ptr and incrementing wr_ptr.
REQ-018 A write while full SHALL be dropped, even when read_enb=1 in the same cycle.
REQ-019 A read SHALL occur when read_enb=1 and empty=0, loading entry[rd_ptr][7:0] into data_out at the next edge (latency 1) and incrementing rd_ptr.
REQ-020 A read while empty SHALL be ignored, leaving data_out and the pointers unchanged.
REQ-021 A simultaneous legal read and write SHALL both proceed, leaving occupancy unchanged.
REQ-022 Pointer increment SHALL wrap from 31 to 0 with no special case.
REQ-023 A 7-bit byte counter pkt_cnt SHALL be kept:
  - reading an entry with bit 8 = 1 loads pkt_cnt = entry[7:2] + 1 (payload plus parity);
  - reading an entry with bit 8 = 0 and pkt_cnt != 0 decrements pkt_cnt;
  - otherwise pkt_cnt holds.
REQ-024 When pkt_cnt = 0 and no read occurs in a cycle, data_out SHALL become 8'h00 at that edge, so the parity byte is visible for exactly one cycle after the last read unless the next read follows.
REQ-025 soft_reset=1 at a clock edge SHALL clear wr_ptr, rd_ptr, pkt_cnt, data_out and lfd_d, and SHALL take priority over any read or write in that cycle.
REQ-026 A header with payload length 0 (entry[7:2]=0) SHALL load pkt_cnt = 1, so only the parity byte follows.

Reset
REQ-027 resetn=0 SHALL asynchronously force wr_ptr=0, rd_ptr=0, pkt_cnt=0, lfd_d=0 and data_out=8'h00, giving empty=1 and full=0.
REQ-028 Memory contents SHALL NOT be reset; they are unobservable because the pointers are cleared.
REQ-029 Assertion of resetn mid-packet SHALL discard the packet with no residual marker or count.
REQ-030 Deassertion of resetn SHALL be synchronised upstream; the block relies on release at a clock edge boundary being clean.

Structure
REQ-031 Shared package router_pkg SHALL hold: FIFO_DEPTH=16; FIFO_WIDTH=9; HDR_BIT=8; LEN_MSB=7; LEN_LSB=2; PTR_W=5; CNT_W=7.
REQ-032 The block SHALL be a single module with no sub-modules; the memory array is inferred in-line.

Verification
REQ-033 Reset scenario: preload 3 writes, then resetn=0 -> empty=1, full=0 and data_out=00, all within the same cycle (asynchronous).
REQ-034 Packet scenario: lfd_state=1 for one cycle, then write 16,A1,B2,C3,D4,E5,E1, then read 7 times -> data_out=16,A1,B2,C3,D4,E5,E1 with 1-cycle latency, then 00 on the next idle cycle; pkt_cnt = 6 after the header read and 0 after E1.
REQ-035 Full scenario: write 17 bytes 00..10 with no reads -> full=1 after the 16th, 17th byte dropped; 16 reads return 00..0F, then empty=1.
REQ-036 Simultaneous scenario: at occupancy 8, read_enb=write_enb=1 for 20 cycles -> occupancy stays 8, pointers wrap past 31, data order preserved; same at full -> write dropped, read proceeds, occupancy becomes 15.
REQ-037 Soft reset scenario: soft_reset=1 mid-packet with write_enb=read_enb=1 -> next cycle empty=1, data_out=00; a following fresh header 0x0A reads back with pkt_cnt=3.
REQ-038 Empty scenario: read_enb=1 while empty -> data_out and rd_ptr unchanged.
